// File: rtl/btb_nway.sv
// btb_nway -- N-way set-associative branch target buffer for the fetch stage.
//
// Each entry holds a tag, a branch target and a 2-bit saturating direction
// counter, so one lookup predicts both where a branch goes and whether it
// is taken. Replacement is a tree-PLRU generalised to any power-of-two N.
// A multi-cycle flush engine clears the table one set per cycle.
//
// Lookup is combinational on i_pc. Updates come from execute-stage branch
// resolution and land on the next posedge; a lookup in the same cycle sees
// the old contents.
//
// Ports:
//   i_clk, i_arst_n    clock, asynchronous active-low reset
//   i_stall_fetch      holds updates and flush steps
//   i_pc               fetch PC to look up
//   i_upd_*            resolved branch: pc, taken, hit/way seen at lookup,
//                      target
//   i_flush            start invalidation of the whole table
//   o_hit              valid tag match for i_pc
//   o_pred_taken       hit and counter MSB set
//   o_target_addr      target of hit way (don't-care on miss)
//   o_way              hit way, or allocation victim on miss
//   o_busy             flush in progress
//
// Optional build macro BTB_PERF_EN adds 32-bit o_lookup_cnt / o_hit_cnt
// counters of non-stalled idle lookups and of those that hit.

module btb_nway #(
   parameter int SET_COUNT  = 4,
   parameter int N          = 4,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                    i_clk,
   input  logic                    i_arst_n,
   input  logic                    i_stall_fetch,
   input  logic [ADDR_WIDTH-1:0]   i_pc,
   input  logic                    i_upd_valid,
   input  logic [ADDR_WIDTH-1:0]   i_upd_pc,
   input  logic                    i_upd_taken,
   input  logic                    i_upd_hit,
   input  logic [$clog2(N)-1:0]    i_upd_way,
   input  logic [ADDR_WIDTH-1:0]   i_upd_target,
   input  logic                    i_flush,
   output logic                    o_hit,
   output logic                    o_pred_taken,
   output logic [ADDR_WIDTH-1:0]   o_target_addr,
   output logic [$clog2(N)-1:0]    o_way,
   output logic                    o_busy
`ifdef BTB_PERF_EN
   ,
   output logic [31:0]             o_lookup_cnt,
   output logic [31:0]             o_hit_cnt
`endif
);

   localparam int IDX_W = $clog2(SET_COUNT);
   localparam int WAY_W = $clog2(N);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

   typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

   // PLRU tree is heap-ordered: node 0 is the root, node k at level l
   // covers ways whose top l bits equal k-(2^l-1). A node bit of 0 points
   // the victim into the left (lower-numbered) subtree.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [N-2:0] bits);
      logic [WAY_W-1:0] v;
      logic             match;
      logic             b;
      v = '0;
      for (int w = N-1; w >= 0; w--) begin
         match = 1'b1;
         for (int l = 0; l < WAY_W; l++) begin
            b = 1'((w >> (WAY_W-1-l)) & 1);
            if (bits[(1 << l) - 1 + (w >> (WAY_W-l))] != b) match = 1'b0;
         end
         if (match) v = WAY_W'(w);
      end
      return v;
   endfunction

   // Point every node on the path to 'way' away from it.
   function automatic logic [N-2:0] plru_touch(input logic [N-2:0] bits,
                                               input logic [WAY_W-1:0] way);
      logic [N-2:0] r;
      logic         b;
      r = bits;
      for (int w = 0; w < N; w++) begin
         if (way == WAY_W'(w)) begin
            for (int l = 0; l < WAY_W; l++) begin
               b = 1'((w >> (WAY_W-1-l)) & 1);
               r[(1 << l) - 1 + (w >> (WAY_W-l))] = ~b;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
      logic [1:0] n;
      n = c;
      if (taken) begin
         if (c != 2'b11) n = c + 2'd1;
      end else begin
         if (c != 2'b00) n = c - 2'd1;
      end
      return n;
   endfunction

   // State
   state_t                                          state_q, state_d;
   logic [IDX_W-1:0]                                flush_idx_q, flush_idx_d;
   logic [SET_COUNT-1:0][N-1:0]                     valid_q, valid_d;
   logic [SET_COUNT-1:0][N-1:0][1:0]                ctr_q, ctr_d;
   logic [SET_COUNT-1:0][N-2:0]                     plru_q, plru_d;
   logic [SET_COUNT-1:0][N-1:0][TAG_W-1:0]          tag_q, tag_d;
   logic [SET_COUNT-1:0][N-1:0][ADDR_WIDTH-1:0]     tgt_q, tgt_d;

   // Lookup
   logic [IDX_W-1:0] lk_set;
   logic [TAG_W-1:0] lk_tag;
   logic             hit_raw;
   logic [WAY_W-1:0] hit_way;
   logic             inv_found;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] victim;

   // Byte-offset bits of the PCs carry no information for the BTB.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_pc[1:0], i_upd_pc[1:0]};

   assign lk_set = i_pc[IDX_W+1:2];
   assign lk_tag = i_pc[ADDR_WIDTH-1:IDX_W+2];

   always_comb begin
      hit_raw   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      // Descending scan so the lowest matching / invalid way wins.
      for (int w = N-1; w >= 0; w--) begin
         if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
            hit_raw = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[lk_set][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : plru_victim(plru_q[lk_set]);
   end

   assign o_hit         = hit_raw & (state_q == ST_IDLE);
   assign o_pred_taken  = o_hit & ctr_q[lk_set][hit_way][1];
   assign o_target_addr = tgt_q[lk_set][hit_way];
   assign o_way         = hit_raw ? hit_way : victim;
   assign o_busy        = (state_q == ST_FLUSH);

   // Update / flush next-state
   logic [IDX_W-1:0] upd_set;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_en;

   assign upd_set = i_upd_pc[IDX_W+1:2];
   assign upd_tag = i_upd_pc[ADDR_WIDTH-1:IDX_W+2];
   assign upd_en  = i_upd_valid & ~i_stall_fetch & (state_q == ST_IDLE);

   always_comb begin
      state_d     = state_q;
      flush_idx_d = flush_idx_q;
      valid_d     = valid_q;
      ctr_d       = ctr_q;
      plru_d      = plru_q;
      tag_d       = tag_q;
      tgt_d       = tgt_q;

      if (state_q == ST_IDLE) begin
         if (upd_en) begin
            if (i_upd_hit) begin
               ctr_d[upd_set][i_upd_way] = ctr_next(ctr_q[upd_set][i_upd_way], i_upd_taken);
               if (i_upd_taken) tgt_d[upd_set][i_upd_way] = i_upd_target;
               plru_d[upd_set] = plru_touch(plru_q[upd_set], i_upd_way);
            end else if (i_upd_taken) begin
               tag_d[upd_set][i_upd_way]   = upd_tag;
               tgt_d[upd_set][i_upd_way]   = i_upd_target;
               valid_d[upd_set][i_upd_way] = 1'b1;
               ctr_d[upd_set][i_upd_way]   = 2'b10;
               plru_d[upd_set] = plru_touch(plru_q[upd_set], i_upd_way);
            end
         end
         if (i_flush) state_d = ST_FLUSH;
      end else if (!i_stall_fetch) begin
         valid_d[flush_idx_q] = '0;
         ctr_d[flush_idx_q]   = '0;
         plru_d[flush_idx_q]  = '0;
         if (flush_idx_q == IDX_W'(SET_COUNT-1)) begin
            state_d     = ST_IDLE;
            flush_idx_d = '0;
         end else begin
            flush_idx_d = flush_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q     <= ST_IDLE;
         flush_idx_q <= '0;
         valid_q     <= '0;
         ctr_q       <= '0;
         plru_q      <= '0;
      end else begin
         state_q     <= state_d;
         flush_idx_q <= flush_idx_d;
         valid_q     <= valid_d;
         ctr_q       <= ctr_d;
         plru_q      <= plru_d;
      end
   end

   // Tag and target storage is qualified by valid, so it needs no reset.
   always_ff @(posedge i_clk) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
   end

`ifdef BTB_PERF_EN
   logic [31:0] lookup_cnt_q, lookup_cnt_d;
   logic [31:0] hit_cnt_q, hit_cnt_d;

   always_comb begin
      lookup_cnt_d = lookup_cnt_q;
      hit_cnt_d    = hit_cnt_q;
      if ((state_q == ST_IDLE) && !i_stall_fetch) begin
         lookup_cnt_d = lookup_cnt_q + 32'd1;
         if (o_hit) hit_cnt_d = hit_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         lookup_cnt_q <= '0;
         hit_cnt_q    <= '0;
      end else begin
         lookup_cnt_q <= lookup_cnt_d;
         hit_cnt_q    <= hit_cnt_d;
      end
   end

   assign o_lookup_cnt = lookup_cnt_q;
   assign o_hit_cnt    = hit_cnt_q;
`endif

endmodule

// File: tb/tb_btb_nway.sv
module tb_btb_nway;

   logic        i_clk = 1'b0;
   logic        i_arst_n;
   logic        i_stall_fetch;
   logic [63:0] i_pc;
   logic        i_upd_valid;
   logic [63:0] i_upd_pc;
   logic        i_upd_taken;
   logic        i_upd_hit;
   logic [1:0]  i_upd_way;
   logic [63:0] i_upd_target;
   logic        i_flush;
   logic        o_hit;
   logic        o_pred_taken;
   logic [63:0] o_target_addr;
   logic [1:0]  o_way;
   logic        o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   btb_nway #(.SET_COUNT(4), .N(4), .ADDR_WIDTH(64)) dut (
      .i_clk(i_clk), .i_arst_n(i_arst_n), .i_stall_fetch(i_stall_fetch),
      .i_pc(i_pc), .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc),
      .i_upd_taken(i_upd_taken), .i_upd_hit(i_upd_hit), .i_upd_way(i_upd_way),
      .i_upd_target(i_upd_target), .i_flush(i_flush), .o_hit(o_hit),
      .o_pred_taken(o_pred_taken), .o_target_addr(o_target_addr),
      .o_way(o_way), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Present one update for one posedge, then withdraw it.
   task automatic upd(input logic [63:0] pc, input logic hit, input logic [1:0] way,
                      input logic taken, input logic [63:0] tgt);
      i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_hit = hit; i_upd_way = way;
      i_upd_taken = taken; i_upd_target = tgt;
      @(posedge i_clk); #1;
      i_upd_valid = 1'b0;
   endtask

   task automatic look(input logic [63:0] pc);
      i_pc = pc; #1;
   endtask

   task automatic test_reset();
      i_arst_n = 1'b1; i_stall_fetch = 1'b0; i_pc = 64'h1000; i_upd_valid = 1'b0;
      i_upd_pc = '0; i_upd_taken = 1'b0; i_upd_hit = 1'b0; i_upd_way = '0;
      i_upd_target = '0; i_flush = 1'b0;
      #2 i_arst_n = 1'b0;
      #2;
      n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", o_hit); end
      n_checks++; if (o_way !== 2'd0) begin n_fail++; $display("FAIL reset_way: got %0d want 0", o_way); end
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      repeat (2) @(posedge i_clk);
      #1 i_arst_n = 1'b1;
      look(64'h1000);
      n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL post_reset_hit: got %b want 0", o_hit); end
   endtask

   task automatic test_alloc();
      i_pc = 64'h1000;
      i_upd_valid = 1'b1; i_upd_pc = 64'h1000; i_upd_hit = 1'b0; i_upd_way = 2'd0;
      i_upd_taken = 1'b1; i_upd_target = 64'h2000;
      #1;
      // Same-cycle lookup must see pre-update contents.
      n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got %b want 0", o_hit); end
      @(posedge i_clk); #1; i_upd_valid = 1'b0;
      look(64'h1000);
      n_checks++; if (o_hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %b want 1", o_hit); end
      n_checks++; if (o_pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred: got %b want 1", o_pred_taken); end
      n_checks++; if (o_target_addr !== 64'h2000) begin n_fail++; $display("FAIL alloc_tgt: got %h want 2000", o_target_addr); end
      n_checks++; if (o_way !== 2'd0) begin n_fail++; $display("FAIL alloc_way: got %0d want 0", o_way); end
   endtask

   task automatic test_counter();
      // {taken, target, expected pred after, expected target after}
      logic        tk [10];
      logic [63:0] tg [10];
      logic        ep [10];
      logic [63:0] et [10];
      tk = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
      tg = '{64'h9000, 64'h9000, 64'h9000, 64'h2000, 64'h2000, 64'h2000, 64'h2000, 64'h3000, 64'h9000, 64'h9000};
      // ctr: 10 -> 01 00 00 01 10 11 11 11 10 01
      ep = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
      et = '{64'h2000, 64'h2000, 64'h2000, 64'h2000, 64'h2000, 64'h2000, 64'h2000, 64'h3000, 64'h3000, 64'h3000};
      for (int i = 0; i < 10; i++) begin
         upd(64'h1000, 1'b1, 2'd0, tk[i], tg[i]);
         look(64'h1000);
         n_checks++;
         if (o_pred_taken !== ep[i]) begin
            n_fail++; $display("FAIL ctr_pred[%0d]: got %b want %b", i, o_pred_taken, ep[i]);
         end
         n_checks++;
         if (o_target_addr !== et[i]) begin
            n_fail++; $display("FAIL ctr_tgt[%0d]: got %h want %h", i, o_target_addr, et[i]);
         end
      end
   endtask

   task automatic test_plru();
      logic [1:0] ew [4];
      ew = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int w = 0; w < 4; w++) begin
         upd(64'h1000 + 64'(w) * 64'h100, 1'b0, 2'(w), 1'b1, 64'h4000 + 64'(w));
         look(64'h1400);
         n_checks++;
         if (o_way !== ew[w]) begin
            n_fail++; $display("FAIL fill_victim[%0d]: got %0d want %0d", w, o_way, ew[w]);
         end
      end
      upd(64'h1000, 1'b1, 2'd0, 1'b1, 64'h4000);
      look(64'h1400);
      n_checks++; if (o_way !== 2'd2) begin n_fail++; $display("FAIL plru_touch0: got %0d want 2", o_way); end
      look(64'h1200);
      n_checks++; if (o_hit !== 1'b1 || o_way !== 2'd2) begin
         n_fail++; $display("FAIL plru_hit2: got hit %b way %0d want hit 1 way 2", o_hit, o_way); end
      upd(64'h1200, 1'b1, 2'd2, 1'b0, 64'h0);
      look(64'h1400);
      n_checks++; if (o_way !== 2'd1) begin n_fail++; $display("FAIL plru_touch2: got %0d want 1", o_way); end
   endtask

   task automatic test_flush();
      int busy_cnt;
      upd(64'h1004, 1'b0, 2'd0, 1'b1, 64'h5000);
      look(64'h1004);
      n_checks++; if (o_hit !== 1'b1) begin n_fail++; $display("FAIL set1_hit: got %b want 1", o_hit); end
      @(posedge i_clk); #1;
      i_flush = 1'b1;
      i_upd_valid = 1'b1; i_upd_pc = 64'h1008; i_upd_hit = 1'b0; i_upd_way = 2'd0;
      i_upd_taken = 1'b1; i_upd_target = 64'h6000;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      // Keep offering a taken miss into set 0 for the whole flush.
      i_upd_pc = 64'h1000; i_upd_target = 64'h7000;
      i_pc = 64'h1004;
      busy_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (!o_busy) break;
         busy_cnt++;
         n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL flush_hit[%0d]: got %b want 0", c, o_hit); end
         @(posedge i_clk);
      end
      i_upd_valid = 1'b0;
      n_checks++; if (busy_cnt != 4) begin n_fail++; $display("FAIL flush_len: got %0d want 4", busy_cnt); end
      look(64'h1000);
      n_checks++; if (o_hit !== 1'b0 || o_way !== 2'd0) begin
         n_fail++; $display("FAIL flush_drop: got hit %b way %0d want 0 0", o_hit, o_way); end
      look(64'h1004);
      n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL flush_set1: got %b want 0", o_hit); end
      look(64'h1008);
      n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL flush_set2: got %b want 0", o_hit); end
      look(64'h1300);
      n_checks++; if (o_hit !== 1'b0 || o_way !== 2'd0) begin
         n_fail++; $display("FAIL flush_set0w3: got hit %b way %0d want 0 0", o_hit, o_way); end
   endtask

   task automatic test_stall_flush();
      int busy_cnt;
      upd(64'h1004, 1'b0, 2'd0, 1'b1, 64'h5000);
      @(posedge i_clk); #1;
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      i_pc = 64'h1004;
      busy_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (!o_busy) break;
         busy_cnt++;
         i_stall_fetch = (busy_cnt >= 2 && busy_cnt <= 4);
         n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL stall_flush_hit[%0d]: got %b want 0", c, o_hit); end
         @(posedge i_clk);
      end
      i_stall_fetch = 1'b0;
      n_checks++; if (busy_cnt != 7) begin n_fail++; $display("FAIL stall_flush_len: got %0d want 7", busy_cnt); end
      look(64'h1004);
      n_checks++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL stall_flush_set1: got %b want 0", o_hit); end
   endtask

   task automatic test_stall_update();
      i_stall_fetch = 1'b1;
      upd(64'h100C, 1'b0, 2'd1, 1'b1, 64'h8000);
      i_stall_fetch = 1'b0;
      look(64'h100C);
      n_checks++; if (o_hit !== 1'b0 || o_way !== 2'd0) begin
         n_fail++; $display("FAIL stall_upd_drop: got hit %b way %0d want 0 0", o_hit, o_way); end
   endtask

   task automatic test_reset_mid_flush();
      upd(64'h100C, 1'b0, 2'd1, 1'b1, 64'h8000);
      look(64'h100C);
      n_checks++; if (o_hit !== 1'b1 || o_way !== 2'd1) begin
         n_fail++; $display("FAIL set3_hit: got hit %b way %0d want 1 1", o_hit, o_way); end
      @(posedge i_clk); #1;
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      @(posedge i_clk); #1;
      n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_flush_busy: got %b want 1", o_busy); end
      i_arst_n = 1'b0;
      #1;
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
      n_checks++; if (o_hit !== 1'b0 || o_way !== 2'd0) begin
         n_fail++; $display("FAIL rst_mid_clear: got hit %b way %0d want 0 0", o_hit, o_way); end
      @(posedge i_clk); #1;
      i_arst_n = 1'b1;
      @(posedge i_clk); #1;
      look(64'h100C);
      n_checks++; if (o_hit !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_after: got hit %b busy %b want 0 0", o_hit, o_busy); end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_counter();
      test_plru();
      test_flush();
      test_stall_flush();
      test_stall_update();
      test_reset_mid_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btb_nway.md
Name: btb_nway

Overview:
- Parametrised successor to the fixed 4-way fetch-stage BTB.
- N-way set-associative branch target buffer with a generalised tree-PLRU for any power-of-two N.
- Each entry carries a 2-bit saturating direction counter, so the block predicts both target and direction.
- Adds a sequenced multi-cycle flush engine. Sits beside the fetch PC mux; lookup is combinational on the fetch PC, update comes from execute-stage branch resolution.

Parameters:
- SET_COUNT, 4, number of sets (power of two, ≥2).
- N, 4, ways per set (power of two, ≥2).
- ADDR_WIDTH, 64, PC/target width.
- Derived, not overridable:
  - IDX_W = $clog2(SET_COUNT).
  - WAY_W = $clog2(N).
  - TAG_W = ADDR_WIDTH-IDX_W-2.
  - Index = pc[IDX_W+1:2]; tag = pc[ADDR_WIDTH-1:IDX_W+2].

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_stall_fetch  in  1  when high, updates and flush steps are held.
- i_pc  in  ADDR_WIDTH  fetch PC for lookup.
- i_upd_valid  in  1  resolved branch update request.
- i_upd_pc  in  ADDR_WIDTH  PC of resolved branch.
- i_upd_taken  in  1  resolved direction.
- i_upd_hit  in  1  o_hit captured at that branch's lookup.
- i_upd_way  in  WAY_W  o_way captured at that branch's lookup.
- i_upd_target  in  ADDR_WIDTH  resolved target.
- i_flush  in  1  request invalidation of the whole BTB.
- o_hit  out  1  valid tag match at i_pc.
- o_pred_taken  out  1  o_hit & counter[1] of hit way.
- o_target_addr  out  ADDR_WIDTH  target of hit way; don't-care on miss.
- o_way  out  WAY_W  hit way on hit, else allocation victim.
- o_busy  out  1  flush in progress.

Behaviour:
- **Reset (async, i_arst_n low):**
  - All valid bits, PLRU bits and counters are cleared.
  - FSM goes to IDLE; flush index = 0.
  - Outputs: o_hit=0, o_pred_taken=0, o_busy=0, o_way=0 (all ways invalid, lowest invalid way chosen).
  - Tag/target arrays are not reset.
- **Lookup (combinational, zero latency):**
  - Hit way = lowest-index way with valid & tag match.
  - Multiple matches must not occur; if they do, the lowest index wins.
  - Victim on miss = lowest-index invalid way if any exists; otherwise tree-PLRU victim.
  - Tree-PLRU has N-1 node bits per set. Node bit 0 means victim is in the left subtree; walk from the root.
  - During FLUSH: o_hit and o_pred_taken are forced to 0.
- **Update (one posedge; visible to lookup the next cycle):**
  - An update is applied when i_upd_valid & ~i_stall_fetch & state==IDLE. Otherwise it is dropped, not queued.
  - Set index is taken from i_upd_pc; way is i_upd_way.
  - Hit case (i_upd_hit=1):
    - Counter saturating +1 if taken, -1 if not taken (bounded 0..3).
    - If taken, the target is rewritten.
    - PLRU is touched.
  - Miss, taken: write tag, target and valid=1; counter=2'b10 (weakly taken); touch PLRU.
  - Miss, not taken: no state change.
  - PLRU touch: every node on the path to the way is set to point away from it.
- **Same-cycle lookup and update to the same set/way:** lookup returns pre-update contents (no bypass).
- **FSM, IDLE → FLUSH:**
  - Entered on i_flush in IDLE.
  - o_busy goes high the cycle after i_flush.
  - An update presented in the i_flush cycle is still applied.
- **FSM, FLUSH:**
  - Each non-stalled cycle clears valid, PLRU and counters of set[flush index], then increments the index.
  - Exits to IDLE after clearing set SET_COUNT-1; the index wraps to 0 and o_busy drops the next cycle.
  - Takes SET_COUNT non-stalled cycles.
  - i_flush during FLUSH is ignored.
  - i_stall_fetch freezes the index.
  - Reset mid-flush: immediate clear and return to IDLE.

Optional Feature:
BTB_PERF_EN:
- **Defined:** adds ports o_lookup_cnt and o_hit_cnt (32 bits each, out), both reset to 0.
  - o_lookup_cnt increments every IDLE cycle with ~i_stall_fetch.
  - o_hit_cnt increments on the same qualifier & o_hit.
  - Both wrap at 2^32. Neither is cleared by flush.
- **Undefined:** ports and counters are absent; all other behaviour is identical.

Test Plan:
- **Reset, then lookup:** reset, then i_pc=0x1000 → o_hit=0, o_way=0, o_busy=0.
- **Allocate and hit:**
  - Stimulus: update pc=0x1000, miss, way 0, taken, target 0x2000; next cycle i_pc=0x1000.
  - Response: o_hit=1, o_pred_taken=1, o_target_addr=0x2000.
- **Counter saturation:**
  - Stimulus: on that entry, 2 not-taken updates with hit=1.
  - Response: counter 10→01→00 and o_pred_taken=0; a 3rd not-taken keeps 00.
  - Then 3 taken updates → counter 11 and o_pred_taken=1.
- **PLRU victim (N=4):**
  - Stimulus: fill ways 0,1,2,3 of set 0 in order with taken misses.
  - Response: miss lookup in set 0 gives o_way=0. Touching way 0 via a hit update then gives o_way=2.
- **Flush:**
  - Stimulus: fill 2 sets, pulse i_flush.
  - Response: o_busy high for exactly SET_COUNT=4 cycles and o_hit=0 throughout. Afterwards all lookups miss and o_way=0.
  - An update during FLUSH is dropped.
- **Stall during flush, reset mid-flush:**
  - Stimulus: assert i_stall_fetch for 3 cycles mid-flush.
  - Response: o_busy extends by 3 cycles. Asserting i_arst_n low mid-flush immediately gives o_busy=0 and all valid cleared.
